// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: valid/ready 16-bit stereo pairs serialised to a Philips I2S DAC, BCK from a clk32 enable divider.
// `define I2S_MONO_MIX_EN to send the (L+R)/2 mono mix in both slots.
module i2s_audio_tx #(
    parameter int CLK_HZ      = 32000000,
    parameter int SAMPLE_RATE = 24000,
    parameter int HALF_DIV    = CLK_HZ / (SAMPLE_RATE * 32) / 2,
    parameter bit OFFSET_IN   = 1'b1
) (
    input  logic        clk32,
    input  logic        por_n,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        i2s_bck,
    output logic        i2s_ws,
    output logic        i2s_din,
    output logic        frame_stb,
    output logic        underrun
);
    localparam int DW = $clog2(HALF_DIV);

    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [4:0]    bit_nxt;
    logic [31:0]   hold;
    logic [31:0]   shift;
    logic [31:0]   last;
    logic [31:0]   conv;
    logic [31:0]   frame;
    logic [15:0]   conv_l;
    logic [15:0]   conv_r;
    logic          hold_full;
    logic          tick;
    logic          fall;
    logic          load_now;
    logic          take;

    assign tick         = div_cnt == DW'(HALF_DIV - 1);
    assign fall         = tick && i2s_bck;
    assign bit_nxt      = bit_cnt + 5'd1;
    assign load_now     = fall && bit_nxt == 5'd0;
    assign sample_ready = por_n && (!hold_full || load_now);
    assign take         = sample_valid && sample_ready;
    assign conv_l       = {sample_l[15] ^ OFFSET_IN, sample_l[14:0]};
    assign conv_r       = {sample_r[15] ^ OFFSET_IN, sample_r[14:0]};
    assign frame        = hold_full ? hold : last;

`ifdef I2S_MONO_MIX_EN
    logic [15:0] mono;
    // 17-bit signed sum halved: bits [16:1] of the sum, which cannot overflow
    assign mono = 16'(({conv_l[15], conv_l} + {conv_r[15], conv_r}) >> 1);
    assign conv = {mono, mono};
`else
    assign conv = {conv_l, conv_r};
`endif

    always_ff @(posedge clk32 or negedge por_n) begin
        if (!por_n) begin
            div_cnt   <= '0;
            bit_cnt   <= 5'd31;
            i2s_bck   <= 1'b0;
            i2s_ws    <= 1'b0;
            i2s_din   <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            last      <= '0;
            frame_stb <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            i2s_bck   <= tick ? !i2s_bck : i2s_bck;
            frame_stb <= load_now;
            underrun  <= load_now && !hold_full;
            hold_full <= take || (hold_full && !load_now);
            if (take)
                hold <= conv;
            // serial state moves on the BCK falling tick so DIN is stable at the rising edge
            if (fall) begin
                bit_cnt <= bit_nxt;
                i2s_ws  <= bit_nxt >= 5'd15 && bit_nxt <= 5'd30;
                if (load_now) begin
                    shift   <= frame;
                    i2s_din <= frame[31];
                    last    <= frame;
                end else begin
                    shift   <= shift << 1;
                    i2s_din <= shift[30];
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: directed vectors with a frame scoreboard for i2s_audio_tx (default parameters).
`timescale 1ns/1ps
module tb_i2s_audio_tx;
    logic        clk32 = 1'b0;
    logic        por_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_ready, i2s_bck, i2s_ws, i2s_din, frame_stb, underrun;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_stb = -1;
    logic        mon_busy = 1'b0;
    logic [32:0] exp_q[$];
    logic [15:0] vl[5], vr[5], el[5], er[5];

    i2s_audio_tx dut (
        .clk32(clk32), .por_n(por_n), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .i2s_bck(i2s_bck),
        .i2s_ws(i2s_ws), .i2s_din(i2s_din), .frame_stb(frame_stb), .underrun(underrun)
    );

    always #5 clk32 = ~clk32;
    always @(posedge clk32) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // release reset and check the first BCK edges and the first (underrun) load
    task automatic release_chk();
        @(posedge clk32); #1 por_n = 1'b1;
        repeat (19) @(posedge clk32);
        #1 chk("bck_low_c19", i2s_bck, 1'b0);
        @(posedge clk32);
        #1 chk("bck_rise_c20", i2s_bck, 1'b1);
        repeat (19) @(posedge clk32);
        #1 chk("bck_high_c39", i2s_bck, 1'b1);
        chk("stb_low_c39", frame_stb, 1'b0);
        @(posedge clk32);
        #1 chk("bck_fall_c40", i2s_bck, 1'b0);
        chk("stb_c40", frame_stb, 1'b1);
        chk("underrun_c40", underrun, 1'b1);
        @(posedge clk32);
        #1 chk("stb_one_cycle", frame_stb, 1'b0);
        chk("underrun_one_cycle", underrun, 1'b0);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || mon_busy) && t < 20000) begin
            @(negedge clk32);
            t++;
        end
        chk("frames_drained", exp_q.size(), 0);
    endtask

    // monitor: on each frame load with an expectation pending, capture DIN/WS at the 32 BCK rising edges
    initial begin : mon
        logic [32:0] e;
        logic [31:0] d, w;
        int t;
        forever begin
            @(negedge clk32);
            if (frame_stb && exp_q.size() != 0) begin
                mon_busy = 1'b1;
                e = exp_q.pop_front();
                chk("frame_underrun", underrun, e[32]);
                if (last_stb >= 0)
                    chk("frame_period", cyc - last_stb, 1280);
                last_stb = cyc;
                t = 0;
                for (int s = 0; s < 32; s++) begin
                    while (!i2s_bck && t < 3000) begin
                        @(negedge clk32);
                        t++;
                    end
                    d[31-s] = i2s_din;
                    w[31-s] = i2s_ws;
                    if (s < 31)
                        while (i2s_bck && t < 3000) begin
                            @(negedge clk32);
                            t++;
                        end
                end
                chk("frame_din", d, e[31:0]);
                chk("frame_ws", w, 32'h0001_FFFE);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : stim
        int t;
        vl = '{16'hC000, 16'h1234, 16'h8000, 16'hFFFF, 16'h7FFF};
        vr = '{16'h3FFF, 16'hABCD, 16'h8000, 16'h0000, 16'hFFFF};
`ifdef I2S_MONO_MIX_EN
        el = '{16'hFFFF, 16'hDF00, 16'h0000, 16'hFFFF, 16'h3FFF};
        er = el;
`else
        el = '{16'h4000, 16'h9234, 16'h0000, 16'h7FFF, 16'hFFFF};
        er = '{16'hBFFF, 16'h2BCD, 16'h0000, 16'h8000, 16'h7FFF};
`endif
        repeat (3) @(posedge clk32);
        #1 chk("rst_bck", i2s_bck, 1'b0);
        chk("rst_ws", i2s_ws, 1'b0);
        chk("rst_din", i2s_din, 1'b0);
        chk("rst_stb", frame_stb, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_ready", sample_ready, 1'b0);

        exp_q.push_back({1'b1, 32'h0});
        release_chk();

        // continuous valid: every accepted pair goes out in the following frame
        for (int i = 0; i < 5; i++) begin
            sample_l = vl[i];
            sample_r = vr[i];
            sample_valid = 1'b1;
            t = 0;
            @(negedge clk32);
            while (!sample_ready && t < 3000) begin
                @(negedge clk32);
                t++;
            end
            if (!sample_ready) begin
                chk("handshake_timeout", sample_ready, 1'b1);
                break;
            end
            if (i == 0)
                chk("accept_immediate", t, 0);
            exp_q.push_back({1'b0, el[i], er[i]});
            @(posedge clk32);
            #1;
            if (i > 0)
                chk("ready_only_at_load", frame_stb, 1'b1);
            chk("ready_drop", sample_ready, 1'b0);
        end
        sample_valid = 1'b0;
        exp_q.push_back({1'b1, el[4], er[4]});
        drain();

        // reset in slot 20 of an ignored frame
        t = 0;
        @(negedge clk32);
        while (!frame_stb && t < 3000) begin
            @(negedge clk32);
            t++;
        end
        repeat (20 * 40 + 10) @(posedge clk32);
        #1 chk("slot20_ws_high", i2s_ws, 1'b1);
        por_n = 1'b0;
        #1 chk("async_bck", i2s_bck, 1'b0);
        chk("async_ws", i2s_ws, 1'b0);
        chk("async_din", i2s_din, 1'b0);
        chk("async_ready", sample_ready, 1'b0);
        last_stb = -1;
        exp_q.push_back({1'b1, 32'h0});
        repeat (2) @(posedge clk32);
        release_chk();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
